// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the data-memory side of the core.
//   RV32I_OPERAND_t : 32-bit operand / address type
//   LSU_STATE_t     : load/store unit sequencer states
//   LSU_B..LSU_HU   : RV32I load/store funct3 encodings
//   word_align()    : clears the byte offset of a byte address
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef logic [31:0] RV32I_OPERAND_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } LSU_STATE_t;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    // The bus only ever sees word addresses, so the decoders downstream
    // can compare addresses exactly.
    function automatic RV32I_OPERAND_t word_align(input RV32I_OPERAND_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the load/store unit.
// Ports:
//   we         in   1   1 = store, 0 = load
//   funct3     in   3   RV32I funct3 of the access
//   lane       in   2   byte offset of the access (addr[1:0])
//   wdata      in   32  store data, low bytes significant for SB/SH
//   rddata     in   32  word read from the bus
//   load_data  out  32  selected lane, sign/zero extended (LW passthrough)
//   store_word out  32  word to write: rddata with addressed lanes replaced
//   err        out  1   misaligned address or illegal funct3
// ---------------------------------------------------------------------------
module lsu_align
    import mem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rddata,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic        err
);

    RV32I_OPERAND_t byte_sel;
    RV32I_OPERAND_t half_sel;

    // Load path: pick the addressed byte/halfword and extend it.
    always_comb begin
        byte_sel  = {24'd0, rddata[{lane, 3'b000} +: 8]};
        half_sel  = {16'd0, (lane[1] ? rddata[31:16] : rddata[15:0])};
        load_data = rddata;
        case (funct3)
            LSU_B:   load_data = {{24{byte_sel[7]}}, byte_sel[7:0]};
            LSU_H:   load_data = {{16{half_sel[15]}}, half_sel[15:0]};
            LSU_BU:  load_data = byte_sel;
            LSU_HU:  load_data = half_sel;
            default: load_data = rddata;
        endcase
    end

    // Store path: sub-word stores merge into the word just read back,
    // so untouched lanes keep their memory contents.
    always_comb begin
        store_word = rddata;
        case (funct3)
            LSU_B: store_word[{lane, 3'b000} +: 8] = wdata[7:0];
            LSU_H: begin
                if (lane[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0] = wdata[15:0];
                end
            end
            default: store_word = wdata;
        endcase
    end

    // Misalignment and illegal encodings; BU/HU do not exist as stores.
    always_comb begin
        err = 1'b0;
        if (we) begin
            case (funct3)
                LSU_B:   err = 1'b0;
                LSU_H:   err = lane[0];
                LSU_W:   err = (lane != 2'b00);
                default: err = 1'b1;
            endcase
        end else begin
            case (funct3)
                LSU_B, LSU_BU: err = 1'b0;
                LSU_H, LSU_HU: err = lane[0];
                LSU_W:         err = (lane != 2'b00);
                default:       err = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Bus initiator for the core's data-memory side. Turns RV32I load/store
// requests into word-aligned bus transactions, waits out the read latency,
// extends load data and performs byte/halfword stores by read-modify-write.
// Parameter:
//   RD_LATENCY  cycles from stable bus_addr to valid bus_rddata (0..7)
// Ports:
//   clk          in   1   core clock
//   rst          in   1   asynchronous, active-low reset
//   req_valid    in   1   request present (sampled while req_ready=1)
//   req_we       in   1   1 = store, 0 = load
//   req_funct3   in   3   RV32I funct3
//   req_addr     in   32  byte address
//   req_wdata    in   32  store data
//   req_ready    out  1   unit idle; request accepted if req_valid=1
//   rsp_valid    out  1   one-cycle completion pulse
//   rsp_rdata    out  32  extended load data (0 for stores and errors)
//   rsp_err      out  1   misaligned/illegal access, qualified by rsp_valid
//   bus_addr     out  32  word-aligned bus address
//   bus_wrdata   out  32  full-word write data
//   bus_wren     out  1   write strobe, one cycle per store
//   bus_rddata   in   32  read data from memory_controller
// ---------------------------------------------------------------------------
module load_store_unit
    import mem_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wrdata,
    output logic        bus_wren,
    input  logic [31:0] bus_rddata
);

    localparam logic [2:0] RD_LAT = 3'(RD_LATENCY);

    LSU_STATE_t state;
    LSU_STATE_t next_state;

    logic        lat_we;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_lane;
    logic [31:0] lat_wdata;
    logic [2:0]  rd_cnt;

    logic        accept;
    logic        rd_done;

    logic        al_we;
    logic [2:0]  al_funct3;
    logic [1:0]  al_lane;
    logic [31:0] al_wdata;
    logic [31:0] al_load_data;
    logic [31:0] al_store_word;
    logic        al_err;

    logic        rsp_valid_d;
    logic [31:0] rsp_rdata_d;
    logic        rsp_err_d;
    logic [31:0] bus_addr_d;
    logic [31:0] bus_wrdata_d;
    logic        bus_wren_d;

    assign req_ready = (state == IDLE);
    assign accept    = (state == IDLE) && req_valid;
    assign rd_done   = (state == READ) && (rd_cnt == 3'd0);

    // In IDLE the lane logic looks at the live request so errors and SW
    // data are known in the accept cycle; afterwards it uses the latch.
    assign al_we     = (state == IDLE) ? req_we         : lat_we;
    assign al_funct3 = (state == IDLE) ? req_funct3     : lat_funct3;
    assign al_lane   = (state == IDLE) ? req_addr[1:0]  : lat_lane;
    assign al_wdata  = (state == IDLE) ? req_wdata      : lat_wdata;

    lsu_align u_align (
        .we         (al_we),
        .funct3     (al_funct3),
        .lane       (al_lane),
        .wdata      (al_wdata),
        .rddata     (bus_rddata),
        .load_data  (al_load_data),
        .store_word (al_store_word),
        .err        (al_err)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: only SW skips the read; sub-word stores need the
    // old word first so untouched lanes survive.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (al_err) begin
                        next_state = RESP;
                    end else if (req_we && (req_funct3 == LSU_W)) begin
                        next_state = WRITE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            READ: begin
                if (rd_cnt == 3'd0) begin
                    next_state = lat_we ? WRITE : RESP;
                end
            end
            WRITE:   next_state = IDLE;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: computes the values the registered outputs take in the
    // state being entered, so every external output comes from a flop.
    always_comb begin
        rsp_valid_d  = 1'b0;
        bus_wren_d   = 1'b0;
        rsp_rdata_d  = rsp_rdata;
        rsp_err_d    = rsp_err;
        bus_addr_d   = bus_addr;
        bus_wrdata_d = bus_wrdata;
        if (accept && !al_err) begin
            bus_addr_d = word_align(req_addr);
        end
        case (next_state)
            WRITE: begin
                bus_wren_d   = 1'b1;
                bus_wrdata_d = al_store_word;
                rsp_valid_d  = 1'b1;
                rsp_rdata_d  = 32'd0;
                rsp_err_d    = 1'b0;
            end
            RESP: begin
                // RESP entered straight from IDLE only happens on an error.
                rsp_valid_d = 1'b1;
                rsp_err_d   = (state == IDLE);
                rsp_rdata_d = (state == IDLE) ? 32'd0 : al_load_data;
            end
            default: begin
            end
        endcase
    end

    // Request latch and read-latency counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_we     <= 1'b0;
            lat_funct3 <= 3'd0;
            lat_lane   <= 2'd0;
            lat_wdata  <= 32'd0;
            rd_cnt     <= 3'd0;
        end else if (accept) begin
            lat_we     <= req_we;
            lat_funct3 <= req_funct3;
            lat_lane   <= req_addr[1:0];
            lat_wdata  <= req_wdata;
            rd_cnt     <= RD_LAT;
        end else if ((state == READ) && !rd_done) begin
            rd_cnt <= rd_cnt - 3'd1;
        end
    end

    // Registered outputs; reset clears them at once, which also kills an
    // in-flight write strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
            bus_addr   <= 32'd0;
            bus_wrdata <= 32'd0;
            bus_wren   <= 1'b0;
        end else begin
            rsp_valid  <= rsp_valid_d;
            rsp_rdata  <= rsp_rdata_d;
            rsp_err    <= rsp_err_d;
            bus_addr   <= bus_addr_d;
            bus_wrdata <= bus_wrdata_d;
            bus_wren   <= bus_wren_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit with RD_LATENCY = 1. A small bus model
// returns the memory word only once bus_addr has been stable long enough.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int          RD_LAT        = 1;
    localparam logic [31:0] GPIO_OUT_ADDR = 32'h4000_0000;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] bus_addr;
    logic [31:0] bus_wrdata;
    logic        bus_wren;
    logic [31:0] bus_rddata;

    logic [31:0] mem_word;
    logic [31:0] prev_addr;
    int          addr_age;

    int total = 0;
    int bad   = 0;

    load_store_unit #(.RD_LATENCY(RD_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .bus_addr   (bus_addr),
        .bus_wrdata (bus_wrdata),
        .bus_wren   (bus_wren),
        .bus_rddata (bus_rddata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus model: data is only valid RD_LAT cycles after bus_addr settles.
    always @(negedge clk) begin
        if (bus_addr !== prev_addr) begin
            prev_addr = bus_addr;
            addr_age  = 0;
        end else if (addr_age < 100) begin
            addr_age = addr_age + 1;
        end
    end
    assign bus_rddata = (addr_age >= RD_LAT) ? mem_word : 32'h5A5A_5A5A;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issues one request and watches the following cycles for the response
    // and any write strobe, then checks timing and values.
    task automatic apply_stimulus(input string tag, input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] word, input int exp_lat,
                                  input logic [31:0] exp_rdata, input logic exp_err,
                                  input logic [31:0] exp_wrdata, input logic [31:0] exp_addr);
        int          rsp_cnt;
        int          rsp_cyc;
        int          wren_cnt;
        int          wren_cyc;
        logic [31:0] got_rdata;
        logic        got_err;
        logic [31:0] got_wrdata;
        logic        ready_after;
        rsp_cnt     = 0;
        rsp_cyc     = -1;
        wren_cnt    = 0;
        wren_cyc    = -1;
        got_rdata   = 32'hxxxx_xxxx;
        got_err     = 1'bx;
        got_wrdata  = 32'hxxxx_xxxx;
        ready_after = 1'b0;
        mem_word    = word;
        req_we      = we;
        req_funct3  = f3;
        req_addr    = addr;
        req_wdata   = wdata;
        req_valid   = 1'b1;
        check_output({tag, "_ready_in"}, {31'd0, req_ready}, 32'd1);
        tick();
        // Scramble the request bus so only the latched copy can be used.
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'b111;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = ~wdata;
        for (int n = 1; n <= exp_lat + 2; n++) begin
            if (n == 1) begin
                check_output({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
                if (!exp_err) begin
                    check_output({tag, "_bus_addr"}, bus_addr, exp_addr);
                end
            end
            if (n == rsp_cyc + 1) begin
                ready_after = req_ready;
            end
            if (rsp_valid === 1'b1) begin
                rsp_cnt++;
                rsp_cyc   = n;
                got_rdata = rsp_rdata;
                got_err   = rsp_err;
            end
            if (bus_wren === 1'b1) begin
                wren_cnt++;
                wren_cyc   = n;
                got_wrdata = bus_wrdata;
            end
            tick();
        end
        check_output({tag, "_rsp_count"}, rsp_cnt, 32'd1);
        check_output({tag, "_rsp_cycle"}, rsp_cyc, exp_lat);
        check_output({tag, "_rdata"}, got_rdata, exp_rdata);
        check_output({tag, "_err"}, {31'd0, got_err}, {31'd0, exp_err});
        check_output({tag, "_ready_after"}, {31'd0, ready_after}, 32'd1);
        if (we && !exp_err) begin
            check_output({tag, "_wren_count"}, wren_cnt, 32'd1);
            check_output({tag, "_wren_cycle"}, wren_cyc, exp_lat);
            check_output({tag, "_wrdata"}, got_wrdata, exp_wrdata);
        end else begin
            check_output({tag, "_no_wren"}, wren_cnt, 32'd0);
        end
    endtask

    initial begin
        int quiet_wren;
        int quiet_rsp;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        mem_word   = 32'd0;
        prev_addr  = 32'd0;
        addr_age   = 0;

        #12;
        check_output("reset_ready",  {31'd0, req_ready}, 32'd1);
        check_output("reset_rsp",    {31'd0, rsp_valid}, 32'd0);
        check_output("reset_wren",   {31'd0, bus_wren},  32'd0);
        check_output("reset_addr",   bus_addr,           32'd0);
        check_output("reset_rdata",  rsp_rdata,          32'd0);
        check_output("reset_err",    {31'd0, rsp_err},   32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Loads: latency RD_LAT+2 = 3 cycles.
        apply_stimulus("lw",  1'b0, 3'b010, 32'h1001_0004, 32'd0, 32'hDEAD_BEEF, 3,
                       32'hDEAD_BEEF, 1'b0, 32'd0, 32'h1001_0004);
        apply_stimulus("lb",  1'b0, 3'b000, 32'h1001_0003, 32'd0, 32'h80FF_1234, 3,
                       32'hFFFF_FF80, 1'b0, 32'd0, 32'h1001_0000);
        apply_stimulus("lbu", 1'b0, 3'b100, 32'h1001_0003, 32'd0, 32'h80FF_1234, 3,
                       32'h0000_0080, 1'b0, 32'd0, 32'h1001_0000);
        apply_stimulus("lh",  1'b0, 3'b001, 32'h1001_0002, 32'd0, 32'h80FF_1234, 3,
                       32'hFFFF_80FF, 1'b0, 32'd0, 32'h1001_0000);
        apply_stimulus("lhu", 1'b0, 3'b101, 32'h1001_0000, 32'd0, 32'h80FF_9234, 3,
                       32'h0000_9234, 1'b0, 32'd0, 32'h1001_0000);

        // Errors: response at T+1, data 0, no write.
        apply_stimulus("lw_mis", 1'b0, 3'b010, 32'h1001_0002, 32'd0, 32'h1234_5678, 1,
                       32'd0, 1'b1, 32'd0, 32'd0);
        apply_stimulus("sh_mis", 1'b1, 3'b001, 32'h1001_0001, 32'h0000_BEEF, 32'h1234_5678, 1,
                       32'd0, 1'b1, 32'd0, 32'd0);
        apply_stimulus("ld_011", 1'b0, 3'b011, 32'h1001_0000, 32'd0, 32'h1234_5678, 1,
                       32'd0, 1'b1, 32'd0, 32'd0);
        apply_stimulus("st_100", 1'b1, 3'b100, 32'h1001_0000, 32'h0000_0001, 32'h1234_5678, 1,
                       32'd0, 1'b1, 32'd0, 32'd0);

        // Stores: SB/SH read-modify-write, SW direct.
        apply_stimulus("sb", 1'b1, 3'b000, 32'h1001_0001, 32'hFFFF_FFAB, 32'h1122_3344, 3,
                       32'd0, 1'b0, 32'h1122_AB44, 32'h1001_0000);
        apply_stimulus("sh", 1'b1, 3'b001, 32'h1001_0002, 32'hCAFE_BEEF, 32'h1122_3344, 3,
                       32'd0, 1'b0, 32'hBEEF_3344, 32'h1001_0000);
        apply_stimulus("sw", 1'b1, 3'b010, GPIO_OUT_ADDR, 32'h0000_0005, 32'h0000_0000, 1,
                       32'd0, 1'b0, 32'h0000_0005, GPIO_OUT_ADDR);
        apply_stimulus("lw2", 1'b0, 3'b010, 32'h1001_0004, 32'd0, 32'hDEAD_BEEF, 3,
                       32'hDEAD_BEEF, 1'b0, 32'd0, 32'h1001_0004);

        // Reset in the middle of an SH read phase.
        mem_word   = 32'h1122_3344;
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h1001_0000;
        req_wdata  = 32'h0000_7777;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_output("midrst_wren",   {31'd0, bus_wren},  32'd0);
        check_output("midrst_rsp",    {31'd0, rsp_valid}, 32'd0);
        check_output("midrst_addr",   bus_addr,           32'd0);
        check_output("midrst_wrdata", bus_wrdata,         32'd0);
        check_output("midrst_rdata",  rsp_rdata,          32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        quiet_wren = 0;
        quiet_rsp  = 0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (bus_wren === 1'b1) quiet_wren++;
            if (rsp_valid === 1'b1) quiet_rsp++;
        end
        check_output("midrst_no_wren", quiet_wren, 32'd0);
        check_output("midrst_no_rsp",  quiet_rsp,  32'd0);
        check_output("midrst_ready",   {31'd0, req_ready}, 32'd1);

        apply_stimulus("lhu_after", 1'b0, 3'b101, 32'h1001_0002, 32'd0, 32'h1122_3344, 3,
                       32'h0000_1122, 1'b0, 32'd0, 32'h1001_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
